// File: rtl/clk_div_50_to_4.sv
// Fractional clock divider: clk4 has a period of DIV_X2 clk50 half-cycles and is high
// for the first floor(DIV_X2/2) of them. Both clk50 edges are used, so odd ratios work too.
module clk_div_50_to_4 #(
    parameter int DIV_X2 = 25
) (
    input  logic clk50,
    input  logic reset_n,
    output logic clk4
);

    localparam bit ODD = (DIV_X2 % 2) != 0;
    // The waveform repeats every T half-cycles, which is M clk50 cycles.
    localparam int T   = ODD ? 2 * DIV_X2 : DIV_X2;
    localparam int M   = T / 2;
    localparam int H   = DIV_X2 / 2;
    localparam int CW  = (M > 1) ? $clog2(M) : 1;

    if (DIV_X2 < 4) begin : g_bad_div
        $error("clk_div_50_to_4: DIV_X2 must be >= 4");
    end

    // Posedge flop covers the even-aligned part of each high interval [a,b),
    // the negedge flop covers the odd-aligned part; their OR reproduces [a,b).
    function automatic int p_lo(input int a);
        return a + (a % 2);
    endfunction

    function automatic int p_hi(input int a, input int b);
        return (((a % 2) == 1 && (b % 2) == 1) || (b <= a)) ? p_lo(a) : b - (b % 2);
    endfunction

    function automatic int n_lo(input int a);
        return a + 1 - (a % 2);
    endfunction

    function automatic int n_hi(input int a, input int b);
        return (((a % 2) == 0 && (b % 2) == 0) || (b <= a)) ? n_lo(a) : b - 1 + (b % 2);
    endfunction

    function automatic logic in_span(input int h, input int lo, input int hi);
        return (h >= lo) && (h < hi);
    endfunction

    // High intervals: [0,H) and, for odd ratios, [DIV_X2, DIV_X2+H).
    localparam int A0 = 0;
    localparam int B0 = H;
    localparam int A1 = ODD ? DIV_X2 : 0;
    localparam int B1 = ODD ? DIV_X2 + H : 0;

    localparam int PLO0 = p_lo(A0);
    localparam int PHI0 = p_hi(A0, B0);
    localparam int NLO0 = n_lo(A0);
    localparam int NHI0 = n_hi(A0, B0);
    localparam int PLO1 = p_lo(A1);
    localparam int PHI1 = p_hi(A1, B1);
    localparam int NLO1 = n_lo(A1);
    localparam int NHI1 = n_hi(A1, B1);

    logic [CW-1:0] cnt;
    logic          pos_q;
    logic          neg_q;
    logic          pos_d;
    logic          neg_d;
    int            hp;
    int            hn;

    // hp: half-cycle index starting at the coming posedge; hn: index starting at the
    // coming negedge, which follows the posedge that already advanced cnt.
    always_comb begin
        hp    = 2 * int'(cnt);
        hn    = (cnt == '0) ? T - 1 : 2 * int'(cnt) - 1;
        pos_d = in_span(hp, PLO0, PHI0) || in_span(hp, PLO1, PHI1);
        neg_d = in_span(hn, NLO0, NHI0) || in_span(hn, NLO1, NHI1);
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            pos_q <= 1'b0;
        end else begin
            cnt   <= (cnt == CW'(M - 1)) ? '0 : cnt + CW'(1);
            pos_q <= pos_d;
        end
    end

    always_ff @(negedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign clk4 = pos_q | neg_q;

endmodule

// File: tb/tb_clk_div_50_to_4.sv
// Bench for clk_div_50_to_4: default ratio (25) and DIV_X2=8 side by side, checked
// every clk50 half-cycle against a waveform model, plus rising-edge counts per run.
module tb_clk_div_50_to_4;

    logic clk50   = 1'b0;
    logic reset_n = 1'b1;
    logic clk4;
    logic clk4_8;

    always #10 clk50 = ~clk50;

    clk_div_50_to_4 dut (
        .clk50  (clk50),
        .reset_n(reset_n),
        .clk4   (clk4)
    );

    clk_div_50_to_4 #(.DIV_X2(8)) dut8 (
        .clk50  (clk50),
        .reset_n(reset_n),
        .clk4   (clk4_8)
    );

    typedef struct {
        int reset_cycles;
        int run_half;
        int exp_rises25;
        int exp_rises8;
    } vec_t;

    vec_t vecs[3];
    int   tests = 0;
    int   fails = 0;
    int   h     = 0;
    logic q25[$];
    logic q8[$];

    // Model: within each period of n half-cycles, high for the first n/2 (rounded down).
    function automatic logic model(input int n, input int hh);
        return (hh % n) < (n / 2);
    endfunction

    task automatic check(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at t=%0t h=%0d", nm, act, exp, $time, h);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One scoreboard step per clk50 edge: push expectation, sample mid half-cycle, pop.
    task automatic step(input logic in_reset, input string tag);
        @(clk50);
        q25.push_back(in_reset ? 1'b0 : model(25, h));
        q8.push_back(in_reset ? 1'b0 : model(8, h));
        if (!in_reset) h++;
        #5;
        check({tag, "_clk4_25"}, clk4, q25.pop_front());
        check({tag, "_clk4_8"}, clk4_8, q8.pop_front());
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        #1;
        check("async_drop_25", clk4, 1'b0);
        check("async_drop_8", clk4_8, 1'b0);
        for (int i = 0; i < 2 * cycles; i++) step(1'b1, "in_reset");
        @(negedge clk50);
        #5;
        reset_n = 1'b1;
        h = 0;
    endtask

    task automatic run_check(input int len, output int r25, output int r8);
        logic p25;
        logic p8;
        p25 = 1'b0;
        p8  = 1'b0;
        r25 = 0;
        r8  = 0;
        for (int i = 0; i < len; i++) begin
            step(1'b0, "run");
            if (clk4 === 1'b1 && p25 === 1'b0) r25++;
            if (clk4_8 === 1'b1 && p8 === 1'b0) r8++;
            p25 = clk4;
            p8  = clk4_8;
        end
    endtask

    initial begin
        int r25;
        int r8;

        vecs[0] = '{reset_cycles: 5, run_half: 1000, exp_rises25: 40, exp_rises8: 125};
        vecs[1] = '{reset_cycles: 3, run_half: 50,   exp_rises25: 2,  exp_rises8: 7};
        vecs[2] = '{reset_cycles: 2, run_half: 13,   exp_rises25: 1,  exp_rises8: 2};

        #2;
        for (int v = 0; v < 3; v++) begin
            do_reset(vecs[v].reset_cycles);
            run_check(vecs[v].run_half, r25, r8);
            check_int($sformatf("rises25_vec%0d", v), r25, vecs[v].exp_rises25);
            check_int($sformatf("rises8_vec%0d", v), r8, vecs[v].exp_rises8);
        end

        // Reset asserted mid-high-phase, then restart from period 0.
        do_reset(2);
        run_check(5, r25, r8);
        check("high_before_reset", clk4, 1'b1);
        do_reset(1);
        run_check(27, r25, r8);
        check_int("rises25_after_midhigh", r25, 2);
        check_int("rises8_after_midhigh", r8, 4);

        // Long run across many wrap-arounds of both counters.
        do_reset(1);
        run_check(25 * 2 * 40, r25, r8);
        check_int("rises25_long", r25, 80);
        check_int("rises8_long", r8, 250);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
